// File: rtl/idu_pkg.sv
// Shared decode encodings for the IDU and EXU: opcodes, control-field codes,
// and the packed control word carried by the decode pipeline register.
package idu_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_COPYB = 4'b0011;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    localparam logic [1:0] BSRC_RS2  = 2'b00;
    localparam logic [1:0] BSRC_IMM  = 2'b01;
    localparam logic [1:0] BSRC_FOUR = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] ext_op;
        logic       reg_wr;
        logic       alu_asrc;
        logic [1:0] alu_bsrc;
        logic [3:0] alu_ctr;
        logic       word;
        logic [2:0] branch;
        logic       mem_to_reg;
        logic       mem_wr;
        logic [2:0] mem_op;
        logic       illegal;
        logic       ebreak;
    } idu_ctrl_t;

    // alt selects sub/sra; the caller decides when func7[5] is meaningful.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32I/RV64I decoder: instruction word in, control word and
// sign-extended immediate out. EBREAK is accepted only when IDU_EBREAK_EN is defined.
module idu_decode
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    output idu_ctrl_t       o_ctrl,
    output logic [XLEN-1:0] o_imm
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_legal;
    logic [31:0] w_imm32;
    idu_ctrl_t   w_ctrl;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];

    always_comb begin
        w_ctrl       = '0;
        w_legal      = 1'b0;
        w_ctrl.rd    = i_inst[11:7];
        w_ctrl.rs1   = i_inst[19:15];
        w_ctrl.rs2   = i_inst[24:20];
        case (w_opcode)
            OPC_LUI: begin
                w_legal         = 1'b1;
                w_ctrl.ext_op   = EXT_U;
                w_ctrl.reg_wr   = 1'b1;
                w_ctrl.alu_bsrc = BSRC_IMM;
                w_ctrl.alu_ctr  = ALU_COPYB;
            end
            OPC_AUIPC: begin
                w_legal         = 1'b1;
                w_ctrl.ext_op   = EXT_U;
                w_ctrl.reg_wr   = 1'b1;
                w_ctrl.alu_asrc = 1'b1;
                w_ctrl.alu_bsrc = BSRC_IMM;
            end
            OPC_JAL: begin
                w_legal         = 1'b1;
                w_ctrl.ext_op   = EXT_J;
                w_ctrl.reg_wr   = 1'b1;
                w_ctrl.alu_asrc = 1'b1;
                w_ctrl.alu_bsrc = BSRC_FOUR;
                w_ctrl.branch   = BR_JAL;
            end
            OPC_JALR: begin
                w_legal         = (w_f3 == 3'b000);
                w_ctrl.reg_wr   = 1'b1;
                w_ctrl.alu_asrc = 1'b1;
                w_ctrl.alu_bsrc = BSRC_FOUR;
                w_ctrl.branch   = BR_JALR;
            end
            OPC_BRANCH: begin
                w_ctrl.ext_op = EXT_B;
                w_legal       = 1'b1;
                case (w_f3)
                    3'b000:  begin w_ctrl.branch = BR_BEQ; w_ctrl.alu_ctr = ALU_SUB;  end
                    3'b001:  begin w_ctrl.branch = BR_BNE; w_ctrl.alu_ctr = ALU_SUB;  end
                    3'b100:  begin w_ctrl.branch = BR_BLT; w_ctrl.alu_ctr = ALU_SLT;  end
                    3'b101:  begin w_ctrl.branch = BR_BGE; w_ctrl.alu_ctr = ALU_SLT;  end
                    3'b110:  begin w_ctrl.branch = BR_BLT; w_ctrl.alu_ctr = ALU_SLTU; end
                    3'b111:  begin w_ctrl.branch = BR_BGE; w_ctrl.alu_ctr = ALU_SLTU; end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_ctrl.reg_wr     = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_bsrc   = BSRC_IMM;
                w_ctrl.mem_op     = w_f3;
                case (w_f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                    3'b011, 3'b110:                         w_legal = RV64;
                    default:                                w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_ctrl.ext_op   = EXT_S;
                w_ctrl.mem_wr   = 1'b1;
                w_ctrl.alu_bsrc = BSRC_IMM;
                w_ctrl.mem_op   = w_f3;
                case (w_f3)
                    3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                    3'b011:                 w_legal = RV64;
                    default:                w_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                w_ctrl.reg_wr   = 1'b1;
                w_ctrl.alu_bsrc = BSRC_IMM;
                w_ctrl.alu_ctr  = alu_from_f3(w_f3, (w_f3 == 3'b101) && i_inst[30]);
                // inst[25] is shamt[5]: only meaningful with a 64-bit datapath.
                if (w_f3 == 3'b001)
                    w_legal = (i_inst[31:26] == 6'b000000) && (RV64 || !i_inst[25]);
                else if (w_f3 == 3'b101)
                    w_legal = ((i_inst[31:26] == 6'b000000) || (i_inst[31:26] == 6'b010000))
                              && (RV64 || !i_inst[25]);
                else
                    w_legal = 1'b1;
            end
            OPC_OP: begin
                w_ctrl.reg_wr  = 1'b1;
                w_ctrl.alu_ctr = alu_from_f3(w_f3, i_inst[30]);
                w_legal = (w_f7 == 7'b0000000) ||
                          ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            OPC_OP_IMM_32: begin
                w_ctrl.reg_wr   = 1'b1;
                w_ctrl.word     = 1'b1;
                w_ctrl.alu_bsrc = BSRC_IMM;
                w_ctrl.alu_ctr  = alu_from_f3(w_f3, (w_f3 == 3'b101) && i_inst[30]);
                w_legal = RV64 && ((w_f3 == 3'b000) ||
                          ((w_f3 == 3'b001) && (w_f7 == 7'b0000000)) ||
                          ((w_f3 == 3'b101) && ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000))));
            end
            OPC_OP_32: begin
                w_ctrl.reg_wr  = 1'b1;
                w_ctrl.word    = 1'b1;
                w_ctrl.alu_ctr = alu_from_f3(w_f3, i_inst[30]);
                w_legal = RV64 && (
                          ((w_f7 == 7'b0000000) && ((w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b101))) ||
                          ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            OPC_SYSTEM: begin
`ifdef IDU_EBREAK_EN
                if (i_inst == INST_EBREAK) begin
                    w_legal       = 1'b1;
                    w_ctrl.ebreak = 1'b1;
                end
`else
                w_legal = 1'b0;
`endif
            end
            default: w_legal = 1'b0;
        endcase
        if (i_inst[1:0] != 2'b11)
            w_legal = 1'b0;
        // Illegal encodings leave only the register indices and the flag.
        if (!w_legal) begin
            w_ctrl         = '0;
            w_ctrl.rd      = i_inst[11:7];
            w_ctrl.rs1     = i_inst[19:15];
            w_ctrl.rs2     = i_inst[24:20];
            w_ctrl.illegal = 1'b1;
        end
    end

    always_comb begin
        case (w_ctrl.ext_op)
            EXT_U:   w_imm32 = {i_inst[31:12], 12'b0};
            EXT_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            EXT_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            EXT_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
        endcase
        o_imm       = {XLEN{w_imm32[31]}};
        o_imm[31:0] = w_imm32;
        if (w_ctrl.illegal)
            o_imm = '0;
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: single-entry valid/ready register around idu_decode.
// Build option IDU_EBREAK_EN enables EBREAK decode (otherwise it is illegal).
module idu_stage
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_ext_op,
    output logic            out_reg_wr,
    output logic            out_alu_asrc,
    output logic [1:0]      out_alu_bsrc,
    output logic [3:0]      out_alu_ctr,
    output logic            out_word,
    output logic [2:0]      out_branch,
    output logic            out_mem_to_reg,
    output logic            out_mem_wr,
    output logic [2:0]      out_mem_op,
    output logic            out_illegal,
    output logic            out_ebreak
);

    idu_ctrl_t       w_ctrl;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;

    idu_ctrl_t       r_ctrl;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;

    idu_decode #(.XLEN(XLEN)) u_decode (
        .i_inst (in_inst),
        .o_ctrl (w_ctrl),
        .o_imm  (w_imm)
    );

    assign in_ready = ~r_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // Flush wins over a simultaneous accept: the IFU still sees the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_imm   <= w_imm;
            r_pc    <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_pc         = r_pc;
    assign out_imm        = r_imm;
    assign out_rd         = r_ctrl.rd;
    assign out_rs1        = r_ctrl.rs1;
    assign out_rs2        = r_ctrl.rs2;
    assign out_ext_op     = r_ctrl.ext_op;
    assign out_reg_wr     = r_ctrl.reg_wr;
    assign out_alu_asrc   = r_ctrl.alu_asrc;
    assign out_alu_bsrc   = r_ctrl.alu_bsrc;
    assign out_alu_ctr    = r_ctrl.alu_ctr;
    assign out_word       = r_ctrl.word;
    assign out_branch     = r_ctrl.branch;
    assign out_mem_to_reg = r_ctrl.mem_to_reg;
    assign out_mem_wr     = r_ctrl.mem_wr;
    assign out_mem_op     = r_ctrl.mem_op;
    assign out_illegal    = r_ctrl.illegal;
    assign out_ebreak     = r_ctrl.ebreak;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: XLEN=32 and XLEN=64 instances share one stimulus stream;
// a decode vector table plus hand-written stall, flush and reset sequences.
module tb_idu_stage;

    typedef struct packed {
        logic        ill;
        logic        word;
        logic        ebrk;
        logic [2:0]  ext;
        logic        rw;
        logic        as;
        logic [1:0]  bs;
        logic [3:0]  alu;
        logic [2:0]  br;
        logic        m2r;
        logic        mw;
        logic [2:0]  mop;
        logic [63:0] imm;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        exp_t        e32;
        exp_t        e64;
    } vec_t;

    localparam int NVEC = 17;
    localparam logic [31:0] I_ADDI = 32'hFFF0_0093;
    localparam logic [31:0] I_LUI  = 32'h1234_5137;
    localparam logic [31:0] I_SW   = 32'h0061_2423;
    localparam logic [31:0] I_BEQ  = 32'hFE20_8EE3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_reg_wr, a_asrc, a_word, a_m2r, a_mw, a_ill, a_ebrk;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_ext, a_br, a_mop;
    logic [1:0]  a_bsrc;
    logic [3:0]  a_alu;

    logic        b_in_ready, b_out_valid, b_reg_wr, b_asrc, b_word, b_m2r, b_mw, b_ill, b_ebrk;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_ext, b_br, b_mop;
    logic [1:0]  b_bsrc;
    logic [3:0]  b_alu;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [NVEC];
    exp_t ill_e;
    exp_t e_eb;
    exp_t a32, a64;

    idu_stage #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
        .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm),
        .out_ext_op(a_ext), .out_reg_wr(a_reg_wr), .out_alu_asrc(a_asrc),
        .out_alu_bsrc(a_bsrc), .out_alu_ctr(a_alu), .out_word(a_word),
        .out_branch(a_br), .out_mem_to_reg(a_m2r), .out_mem_wr(a_mw),
        .out_mem_op(a_mop), .out_illegal(a_ill), .out_ebreak(a_ebrk)
    );

    idu_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_pc),
        .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm),
        .out_ext_op(b_ext), .out_reg_wr(b_reg_wr), .out_alu_asrc(b_asrc),
        .out_alu_bsrc(b_bsrc), .out_alu_ctr(b_alu), .out_word(b_word),
        .out_branch(b_br), .out_mem_to_reg(b_m2r), .out_mem_wr(b_mw),
        .out_mem_op(b_mop), .out_illegal(b_ill), .out_ebreak(b_ebrk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] ext, input logic rw, input logic as,
                                input logic [1:0] bs, input logic [3:0] alu, input logic [2:0] br,
                                input logic m2r, input logic mw, input logic [2:0] mop,
                                input logic word, input logic [63:0] imm);
        exp_t e;
        e      = '0;
        e.ext  = ext;  e.rw  = rw;  e.as = as;   e.bs  = bs;   e.alu = alu;
        e.br   = br;   e.m2r = m2r; e.mw = mw;   e.mop = mop;  e.word = word;
        e.imm  = imm;
        return e;
    endfunction

    task automatic capture();
        a32 = {a_ill, a_word, a_ebrk, a_ext, a_reg_wr, a_asrc, a_bsrc, a_alu, a_br,
               a_m2r, a_mw, a_mop, {{32{a_imm[31]}}, a_imm}};
        a64 = {b_ill, b_word, b_ebrk, b_ext, b_reg_wr, b_asrc, b_bsrc, b_alu, b_br,
               b_m2r, b_mw, b_mop, b_imm};
    endtask

    function automatic vec_t v(input logic [31:0] inst, input logic [4:0] rd,
                               input exp_t e32, input exp_t e64);
        vec_t r;
        r.inst = inst; r.rd = rd; r.e32 = e32; r.e64 = e64;
        return r;
    endfunction

    initial begin
        ill_e     = '0;
        ill_e.ill = 1'b1;
`ifdef IDU_EBREAK_EN
        e_eb      = mk(3'd0, 1'b0, 1'b0, 2'd0, 4'h0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 64'd1);
        e_eb.ebrk = 1'b1;
`else
        e_eb      = ill_e;
`endif
        vecs[0]  = v(I_ADDI,        5'd1,  mk(3'd0,1'b1,1'b0,2'd1,4'h0,3'd0,1'b0,1'b0,3'd0,1'b0,64'hFFFF_FFFF_FFFF_FFFF),
                                           mk(3'd0,1'b1,1'b0,2'd1,4'h0,3'd0,1'b0,1'b0,3'd0,1'b0,64'hFFFF_FFFF_FFFF_FFFF));
        vecs[1]  = v(I_LUI,         5'd2,  mk(3'd1,1'b1,1'b0,2'd1,4'h3,3'd0,1'b0,1'b0,3'd0,1'b0,64'h1234_5000),
                                           mk(3'd1,1'b1,1'b0,2'd1,4'h3,3'd0,1'b0,1'b0,3'd0,1'b0,64'h1234_5000));
        vecs[2]  = v(32'h0000_1197, 5'd3,  mk(3'd1,1'b1,1'b1,2'd1,4'h0,3'd0,1'b0,1'b0,3'd0,1'b0,64'h1000),
                                           mk(3'd1,1'b1,1'b1,2'd1,4'h0,3'd0,1'b0,1'b0,3'd0,1'b0,64'h1000));
        vecs[3]  = v(32'h0080_00EF, 5'd1,  mk(3'd4,1'b1,1'b1,2'd2,4'h0,3'd1,1'b0,1'b0,3'd0,1'b0,64'd8),
                                           mk(3'd4,1'b1,1'b1,2'd2,4'h0,3'd1,1'b0,1'b0,3'd0,1'b0,64'd8));
        vecs[4]  = v(32'h0000_8067, 5'd0,  mk(3'd0,1'b1,1'b1,2'd2,4'h0,3'd2,1'b0,1'b0,3'd0,1'b0,64'd0),
                                           mk(3'd0,1'b1,1'b1,2'd2,4'h0,3'd2,1'b0,1'b0,3'd0,1'b0,64'd0));
        vecs[5]  = v(32'hFFC1_2283, 5'd5,  mk(3'd0,1'b1,1'b0,2'd1,4'h0,3'd0,1'b1,1'b0,3'd2,1'b0,64'hFFFF_FFFF_FFFF_FFFC),
                                           mk(3'd0,1'b1,1'b0,2'd1,4'h0,3'd0,1'b1,1'b0,3'd2,1'b0,64'hFFFF_FFFF_FFFF_FFFC));
        vecs[6]  = v(I_SW,          5'd8,  mk(3'd2,1'b0,1'b0,2'd1,4'h0,3'd0,1'b0,1'b1,3'd2,1'b0,64'd8),
                                           mk(3'd2,1'b0,1'b0,2'd1,4'h0,3'd0,1'b0,1'b1,3'd2,1'b0,64'd8));
        vecs[7]  = v(I_BEQ,         5'd29, mk(3'd3,1'b0,1'b0,2'd0,4'h8,3'd4,1'b0,1'b0,3'd0,1'b0,64'hFFFF_FFFF_FFFF_FFFC),
                                           mk(3'd3,1'b0,1'b0,2'd0,4'h8,3'd4,1'b0,1'b0,3'd0,1'b0,64'hFFFF_FFFF_FFFF_FFFC));
        vecs[8]  = v(32'h0020_E863, 5'd16, mk(3'd3,1'b0,1'b0,2'd0,4'hA,3'd6,1'b0,1'b0,3'd0,1'b0,64'd16),
                                           mk(3'd3,1'b0,1'b0,2'd0,4'hA,3'd6,1'b0,1'b0,3'd0,1'b0,64'd16));
        vecs[9]  = v(32'h4020_81B3, 5'd3,  mk(3'd0,1'b1,1'b0,2'd0,4'h8,3'd0,1'b0,1'b0,3'd0,1'b0,64'h402),
                                           mk(3'd0,1'b1,1'b0,2'd0,4'h8,3'd0,1'b0,1'b0,3'd0,1'b0,64'h402));
        vecs[10] = v(32'h4020_D233, 5'd4,  mk(3'd0,1'b1,1'b0,2'd0,4'hD,3'd0,1'b0,1'b0,3'd0,1'b0,64'h402),
                                           mk(3'd0,1'b1,1'b0,2'd0,4'hD,3'd0,1'b0,1'b0,3'd0,1'b0,64'h402));
        vecs[11] = v(32'h4210_D293, 5'd5,  ill_e,
                                           mk(3'd0,1'b1,1'b0,2'd1,4'hD,3'd0,1'b0,1'b0,3'd0,1'b0,64'h421));
        vecs[12] = v(32'h0000_007F, 5'd0,  ill_e, ill_e);
        vecs[13] = v(32'h0010_809B, 5'd1,  ill_e,
                                           mk(3'd0,1'b1,1'b0,2'd1,4'h0,3'd0,1'b0,1'b0,3'd0,1'b1,64'd1));
        vecs[14] = v(32'h0001_3083, 5'd1,  ill_e,
                                           mk(3'd0,1'b1,1'b0,2'd1,4'h0,3'd0,1'b1,1'b0,3'd3,1'b0,64'd0));
        vecs[15] = v(32'h0010_0073, 5'd0,  e_eb, e_eb);
        vecs[16] = v(32'h0220_81B3, 5'd3,  ill_e, ill_e);

        rst_n = 1'b1; in_valid = 1'b0; in_inst = 32'h0; in_pc = 64'h0;
        flush = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        capture();
        check("reset_valid", {126'b0, a_out_valid, b_out_valid}, 128'd0);
        check("reset_in_ready", {126'b0, a_in_ready, b_in_ready}, 128'd3);
        check("reset_ctrl32", {a32, a_rd, a_rs1, a_rs2, a_pc}, 128'd0);
        check("reset_ctrl64", {a64, b_rd, b_rs1, b_rs2}, 128'd0);
        check("reset_pc64", {64'b0, b_pc}, 128'd0);
        @(negedge clk) rst_n = 1'b1;

        // back-to-back decode, one result per cycle
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = 64'h1000 + 64'(4 * i);
            @(posedge clk);
            #1;
            capture();
            $display("vec %0d inst=%08h valid=%0d/%0d rd=%0d imm32=%08h imm64=%016h ill=%0d/%0d",
                     i, vecs[i].inst, a_out_valid, b_out_valid, a_rd, a_imm, b_imm, a_ill, b_ill);
            check($sformatf("vec%0d_valid", i), {126'b0, a_out_valid, b_out_valid}, 128'd3);
            check($sformatf("vec%0d_rd", i), {118'b0, a_rd, b_rd}, {118'b0, vecs[i].rd, vecs[i].rd});
            check($sformatf("vec%0d_pc", i), {32'b0, a_pc, b_pc},
                  {32'b0, 32'h1000 + 32'(4 * i), 64'h1000 + 64'(4 * i)});
            check($sformatf("vec%0d_x32", i), {42'b0, a32}, {42'b0, vecs[i].e32});
            check($sformatf("vec%0d_x64", i), {42'b0, a64}, {42'b0, vecs[i].e64});
            if (i == 9)
                check("sub_rs", {118'b0, a_rs1, a_rs2}, {118'b0, 5'd1, 5'd2});
        end
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk) #1;
        check("drain_valid", {126'b0, a_out_valid, b_out_valid}, 128'd0);

        // stall with a store held, next instruction waiting at the input
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = I_SW; in_pc = 64'h2000;
        @(posedge clk) #1;
        @(negedge clk) begin in_inst = I_ADDI; in_pc = 64'h2004; end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk) #1;
            $display("stall %0d valid=%0d in_ready=%0d rd=%0d pc=%08h", c, a_out_valid, a_in_ready, a_rd, a_pc);
            check($sformatf("stall%0d_hs", c), {124'b0, a_out_valid, a_in_ready, b_out_valid, b_in_ready}, 128'b1010);
            check($sformatf("stall%0d_hold", c), {83'b0, a_mw, a_mop, a_rd, a_imm, a_pc},
                  {83'b0, 1'b1, 3'd2, 5'd8, 32'd8, 32'h2000});
        end
        @(negedge clk) out_ready = 1'b1;
        #1 check("release_in_ready", {126'b0, a_in_ready, b_in_ready}, 128'd3);
        @(posedge clk) #1;
        $display("release valid=%0d rd=%0d pc=%08h", a_out_valid, a_rd, a_pc);
        check("release_next", {94'b0, a_out_valid, a_rd, a_pc}, {94'b0, 1'b1, 5'd1, 32'h2004});
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk) #1;
        check("release_drain", {126'b0, a_out_valid, b_out_valid}, 128'd0);

        // flush coinciding with an accept
        @(negedge clk);
        in_valid = 1'b1; in_inst = I_BEQ; in_pc = 64'h3000; flush = 1'b1;
        #1 check("flush_in_ready", {126'b0, a_in_ready, b_in_ready}, 128'd3);
        @(posedge clk) #1;
        $display("flush valid=%0d/%0d", a_out_valid, b_out_valid);
        check("flush_valid", {126'b0, a_out_valid, b_out_valid}, 128'd0);
        @(negedge clk) begin flush = 1'b0; in_inst = I_LUI; in_pc = 64'h3004; end
        @(posedge clk) #1;
        $display("post_flush valid=%0d rd=%0d imm=%08h", a_out_valid, a_rd, a_imm);
        check("post_flush", {62'b0, a_out_valid, a_rd, a_imm, a_pc[23:0]},
              {62'b0, 1'b1, 5'd2, 32'h1234_5000, 24'h003004});
        @(negedge clk) in_valid = 1'b0;

        // asynchronous reset while a store is stalled
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = I_SW; in_pc = 64'h4000;
        @(posedge clk) #1;
        check("rst_pre_valid", {126'b0, a_out_valid, b_out_valid}, 128'd3);
        @(negedge clk) in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        $display("async_reset valid=%0d/%0d mem_wr=%0d", a_out_valid, b_out_valid, a_mw);
        check("rst_async", {124'b0, a_out_valid, b_out_valid, a_mw, b_mw}, 128'd0);
        @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
        @(posedge clk) #1;
        check("rst_after", {125'b0, a_out_valid, a_in_ready, b_in_ready}, 128'b011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
